// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard / stall / flush controller.
//
// Purpose:
//   Detects read-after-write hazards between the ID-stage sources and the
//   EX/MEM destinations, tracks memory stalls with a bounded wait FSM that
//   aborts an access after MAX_WAIT stall cycles, prioritises
//   stall > branch flush > hazard bubble for the freeze/flush controls,
//   and counts front-end freeze cycles in a saturating statistics counter.
//
// Parameters:
//   MAX_WAIT  maximum memory-stall cycles per access (2..255)
//   CNT_W     width of stallCount
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   src1, src2, twoSrc       ID-stage sources (src2 valid when twoSrc=1)
//   exWbEn, exMemRead, exDest EX-stage writeback enable, load flag, destination
//   memWbEn, memDest         MEM-stage writeback enable, destination
//   branchTaken              branch resolved taken in EX
//   memReq, memReady         MEM-stage data access request / SRAM completion
//   statClr                  synchronous clear of stallCount
//   hazard                   RAW hazard bubble request
//   freezeIF..freezeEXMEM    stage freeze controls
//   flushIFID, flushIDEX     stage flush controls
//   memStall                 memory access in progress, pipeline held
//   memTimeout               sticky: an access was aborted (cleared by rst)
//   stallCount               saturating count of freezeIF cycles
//
// Build option:
//   PIPE_CTRL_FORWARDING_EN  when defined, only load-use hazards in EX are
//                            reported; MEM-stage matches are ignored.

module pipe_ctrl #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    input  logic             twoSrc,
    input  logic             exWbEn,
    input  logic             exMemRead,
    input  logic [3:0]       exDest,
    input  logic             memWbEn,
    input  logic [3:0]       memDest,
    input  logic             branchTaken,
    input  logic             memReq,
    input  logic             memReady,
    input  logic             statClr,
    output logic             hazard,
    output logic             freezeIF,
    output logic             freezeIFID,
    output logic             freezeIDEX,
    output logic             freezeEXMEM,
    output logic             flushIFID,
    output logic             flushIDEX,
    output logic             memStall,
    output logic             memTimeout,
    output logic [CNT_W-1:0] stallCount
);

    typedef enum logic [1:0] {
        S_RUN,
        S_WAIT,
        S_ABORT
    } state_t;

    localparam logic [8:0] MAX_WAIT_9 = 9'(MAX_WAIT);

    state_t     state;
    logic [7:0] wait_count;
    logic       raw_hazard;
    logic       mem_stall;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Source/destination match. With forwarding, only a load in EX cannot
    // be bypassed, so everything else is left to the forwarding network.
    always_comb begin
        raw_hazard = 1'b0;
`ifdef PIPE_CTRL_FORWARDING_EN
        if (exMemRead && ((src1 == exDest) || (twoSrc && (src2 == exDest))))
            raw_hazard = 1'b1;
`else
        if (exWbEn && ((src1 == exDest) || (twoSrc && (src2 == exDest))))
            raw_hazard = 1'b1;
        if (memWbEn && ((src1 == memDest) || (twoSrc && (src2 == memDest))))
            raw_hazard = 1'b1;
`endif
    end

    // memStall is a Mealy output: it must hold the pipeline in the very
    // cycle the unready request appears, before the FSM has moved to WAIT.
    always_comb begin
        mem_stall = 1'b0;
        if (!rst) begin
            case (state)
                S_RUN:   mem_stall = memReq & ~memReady;
                S_WAIT:  mem_stall = ~memReady;
                default: mem_stall = 1'b0;
            endcase
        end
    end

    // Priority: memory stall, then branch flush, then hazard bubble.
    // A branch held through a stall is therefore flushed in the first
    // unstalled cycle without any extra bookkeeping.
    always_comb begin
        hazard      = raw_hazard & ~branchTaken & ~mem_stall & ~rst;
        memStall    = mem_stall;
        freezeIF    = 1'b0;
        freezeIFID  = 1'b0;
        freezeIDEX  = 1'b0;
        freezeEXMEM = 1'b0;
        flushIFID   = 1'b0;
        flushIDEX   = 1'b0;
        if (rst) begin
            // all controls idle during reset
        end else if (mem_stall) begin
            freezeIF    = 1'b1;
            freezeIFID  = 1'b1;
            freezeIDEX  = 1'b1;
            freezeEXMEM = 1'b1;
        end else if (branchTaken) begin
            flushIFID = 1'b1;
            flushIDEX = 1'b1;
        end else if (hazard) begin
            freezeIF   = 1'b1;
            freezeIFID = 1'b1;
            flushIDEX  = 1'b1;
        end
    end

    // Memory wait FSM. Reset mid-WAIT drops the access silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_RUN;
            wait_count <= 8'd0;
            memTimeout <= 1'b0;
        end else begin
            case (state)
                S_RUN: begin
                    if (memReq && !memReady) begin
                        state      <= S_WAIT;
                        wait_count <= 8'd1;
                    end
                end
                S_WAIT: begin
                    if (memReady) begin
                        state      <= S_RUN;
                        wait_count <= 8'd0;
                    end else if (({1'b0, wait_count} + 9'd1) == MAX_WAIT_9) begin
                        state      <= S_ABORT;
                        wait_count <= 8'd0;
                    end else begin
                        wait_count <= wait_count + 8'd1;
                    end
                end
                S_ABORT: begin
                    memTimeout <= 1'b1;
                    state      <= S_RUN;
                end
                default: begin
                    state      <= S_RUN;
                    wait_count <= 8'd0;
                end
            endcase
        end
    end

    // Front-end freeze statistics; clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || statClr)
            stallCount <= '0;
        else if (freezeIF)
            stallCount <= sat_inc(stallCount);
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] src1, src2, exDest, memDest;
    logic       twoSrc, exWbEn, exMemRead, memWbEn, branchTaken;
    logic       memReq, memReady, statClr;
    logic       hazard, freezeIF, freezeIFID, freezeIDEX, freezeEXMEM;
    logic       flushIFID, flushIDEX, memStall, memTimeout;
    logic [3:0] stallCount;

    always #5 clk = ~clk;

    pipe_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .src1(src1), .src2(src2), .twoSrc(twoSrc),
        .exWbEn(exWbEn), .exMemRead(exMemRead), .exDest(exDest),
        .memWbEn(memWbEn), .memDest(memDest),
        .branchTaken(branchTaken),
        .memReq(memReq), .memReady(memReady), .statClr(statClr),
        .hazard(hazard), .freezeIF(freezeIF), .freezeIFID(freezeIFID),
        .freezeIDEX(freezeIDEX), .freezeEXMEM(freezeEXMEM),
        .flushIFID(flushIFID), .flushIDEX(flushIDEX),
        .memStall(memStall), .memTimeout(memTimeout),
        .stallCount(stallCount)
    );

`ifdef PIPE_CTRL_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {hazard, freezeIF, freezeIFID, freezeIDEX, freezeEXMEM, flushIFID, flushIDEX, memStall}
    localparam logic [7:0] NONE  = 8'b0000_0000;
    localparam logic [7:0] BUB   = 8'b1110_0010;
    localparam logic [7:0] BR    = 8'b0000_0110;
    localparam logic [7:0] STALL = 8'b0111_1001;
    localparam logic [7:0] HZ_FULL = FWD ? NONE : BUB;

    typedef struct {
        string      name;
        logic [7:0] outs;
        logic       tmo;
        logic [3:0] cnt;
    } rec_t;

    typedef struct {
        string      name;
        logic [3:0] s1, s2;
        logic       two, exwb, exrd;
        logic [3:0] exd;
        logic       memwb;
        logic [3:0] memd;
        logic       br;
        logic [7:0] outs;
    } vec_t;

    rec_t       q[$];
    vec_t       vt[9];
    int         total = 0;
    int         bad = 0;
    logic [3:0] sc;

    // Scoreboard checker: one record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t r;
            logic [7:0] act;
            r   = q.pop_front();
            act = {hazard, freezeIF, freezeIFID, freezeIDEX, freezeEXMEM,
                   flushIFID, flushIDEX, memStall};
            total++;
            if (act !== r.outs) begin
                bad++;
                $display("FAIL %s ctrl: got %b want %b", r.name, act, r.outs);
            end
            total++;
            if (memTimeout !== r.tmo) begin
                bad++;
                $display("FAIL %s memTimeout: got %b want %b", r.name, memTimeout, r.tmo);
            end
            total++;
            if (stallCount !== r.cnt) begin
                bad++;
                $display("FAIL %s stallCount: got %0d want %0d", r.name, stallCount, r.cnt);
            end
        end
    end

    task automatic drive(input string nm, input logic [7:0] eo, input logic et);
        rec_t r;
        r.name = nm;
        r.outs = eo;
        r.tmo  = et;
        r.cnt  = sc;
        q.push_back(r);
        if (rst || statClr)
            sc = 4'd0;
        else if (eo[6] && sc != 4'hF)
            sc = sc + 4'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        src1 = 4'd1; src2 = 4'd2; twoSrc = 1'b0;
        exWbEn = 1'b0; exMemRead = 1'b0; exDest = 4'd0;
        memWbEn = 1'b0; memDest = 4'd0; branchTaken = 1'b0;
        memReq = 1'b0; memReady = 1'b0; statClr = 1'b0;
    endtask

    initial begin
        //            name            s1 s2 two exwb exrd exd memwb memd br outs
        vt[0] = '{"ex_raw",        4'd3, 4'd0, 0, 1, 0, 4'd3, 0, 4'd0, 0, HZ_FULL};
        vt[1] = '{"ex_raw_br",     4'd3, 4'd0, 0, 1, 0, 4'd3, 0, 4'd0, 1, BR};
        vt[2] = '{"src2_ignored",  4'd1, 4'd7, 0, 0, 0, 4'd0, 1, 4'd7, 0, NONE};
        vt[3] = '{"src2_mem",      4'd1, 4'd7, 1, 0, 0, 4'd0, 1, 4'd7, 0, HZ_FULL};
        vt[4] = '{"mem_raw",       4'd5, 4'd0, 0, 0, 0, 4'd0, 1, 4'd5, 0, HZ_FULL};
        vt[5] = '{"load_use",      4'd5, 4'd0, 0, 1, 1, 4'd5, 0, 4'd0, 0, BUB};
        vt[6] = '{"ex_wb_off",     4'd3, 4'd0, 0, 0, 0, 4'd3, 0, 4'd0, 0, NONE};
        vt[7] = '{"branch_only",   4'd1, 4'd0, 0, 0, 0, 4'd6, 0, 4'd0, 1, BR};
        vt[8] = '{"load_use_src2", 4'd2, 4'd9, 1, 1, 1, 4'd9, 0, 4'd0, 0, BUB};

        // Reset with hazard and memory request active: controls must stay idle.
        clear_inputs();
        rst = 1'b1;
        src1 = 4'd3; exWbEn = 1'b1; exDest = 4'd3; memReq = 1'b1;
        @(posedge clk);
        #1;
        sc = 4'd0;
        drive("reset", NONE, 1'b0);
        rst = 1'b0;
        clear_inputs();

        // Table-driven hazard / branch vectors, no memory traffic.
        for (int i = 0; i < 9; i++) begin
            src1 = vt[i].s1; src2 = vt[i].s2; twoSrc = vt[i].two;
            exWbEn = vt[i].exwb; exMemRead = vt[i].exrd; exDest = vt[i].exd;
            memWbEn = vt[i].memwb; memDest = vt[i].memd; branchTaken = vt[i].br;
            drive(vt[i].name, vt[i].outs, 1'b0);
        end
        clear_inputs();
        drive("idle", NONE, 1'b0);

        // Memory ready after three low cycles.
        memReq = 1'b1;
        for (int i = 0; i < 3; i++) drive("wait3", STALL, 1'b0);
        memReady = 1'b1;
        drive("wait3_ready", NONE, 1'b0);
        // A fresh access stalls again, proving the FSM went back to RUN.
        memReady = 1'b0;
        drive("rerun_stall", STALL, 1'b0);
        memReady = 1'b1;
        drive("rerun_ready", NONE, 1'b0);
        clear_inputs();

        // Branch and hazard held across a stall: stall wins, then flush.
        memReq = 1'b1; branchTaken = 1'b1;
        src1 = 4'd3; exWbEn = 1'b1; exDest = 4'd3;
        drive("br_in_stall0", STALL, 1'b0);
        drive("br_in_stall1", STALL, 1'b0);
        memReady = 1'b1;
        drive("br_after_stall", BR, 1'b0);
        clear_inputs();

        // Reset in the middle of a wait abandons the access quietly.
        memReq = 1'b1;
        drive("pre_rst_stall", STALL, 1'b0);
        rst = 1'b1;
        drive("rst_mid_wait", NONE, 1'b0);
        rst = 1'b0;
        memReq = 1'b0;
        drive("post_rst", NONE, 1'b0);
        memReq = 1'b1; memReady = 1'b1;
        drive("post_rst_ready", NONE, 1'b0);
        clear_inputs();

        // Memory never ready: 15 stall cycles, one abort cycle, sticky timeout.
        memReq = 1'b1;
        for (int i = 0; i < 15; i++) drive("timeout_stall", STALL, 1'b0);
        drive("abort", NONE, 1'b0);
        memReq = 1'b0;
        for (int i = 0; i < 3; i++) drive("tmo_sticky", NONE, 1'b1);
        src1 = 4'd4; memWbEn = 1'b1; memDest = 4'd4;
        drive("tmo_with_haz", HZ_FULL, 1'b1);
        clear_inputs();
        rst = 1'b1;
        drive("tmo_rst", NONE, 1'b1);
        rst = 1'b0;
        drive("tmo_cleared", NONE, 1'b0);

        // Counter saturation and clear-with-hazard.
        src1 = 4'd5; exWbEn = 1'b1; exMemRead = 1'b1; exDest = 4'd5;
        for (int i = 0; i < 20; i++) drive("sat_haz", BUB, 1'b0);
        statClr = 1'b1;
        drive("clr_with_haz", BUB, 1'b0);
        statClr = 1'b0;
        clear_inputs();
        drive("after_clr", NONE, 1'b0);
        drive("after_clr2", NONE, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
